// File: rtl/msrh_ic_l2_responder.sv
// Instruction-cache line-fill responder: queues IC read requests, fetches each
// line as a sequence of narrow beat reads and returns the assembled line.
module msrh_ic_l2_responder #(
    parameter int              PADDR_W   = 56,
    parameter int              TAG_W     = 4,
    parameter int              LINE_W    = 256,
    parameter int              BEAT_W    = 64,
    parameter int              REQ_DEPTH = 2,
    parameter int              CMD_W     = 5,
    parameter logic [CMD_W-1:0] M_XRD    = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [CMD_W-1:0]   i_req_cmd,
    input  logic [PADDR_W-1:0] i_req_addr,
    input  logic [TAG_W-1:0]   i_req_tag,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [TAG_W-1:0]   o_resp_tag,
    output logic [LINE_W-1:0]  o_resp_data,
    output logic               o_resp_err,
    output logic               o_mem_rd_valid,
    input  logic               i_mem_rd_ready,
    output logic [PADDR_W-1:0] o_mem_rd_addr,
    input  logic               i_mem_rdata_valid,
    input  logic [BEAT_W-1:0]  i_mem_rdata
);

    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BEAT_B = BEAT_W / 8;
    localparam int LINE_B = LINE_W / 8;
    localparam int OFF_W  = $clog2(LINE_B);
    localparam int LA_W   = PADDR_W - OFF_W;
    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam int PTR_W  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int QCNT_W = $clog2(REQ_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT,
        ST_RESP
    } state_t;

    state_t state_reg, state_next;

    // Request queue; only the line-address part of each request is kept.
    logic [CMD_W-1:0]  q_cmd  [REQ_DEPTH];
    logic [LA_W-1:0]   q_line [REQ_DEPTH];
    logic [TAG_W-1:0]  q_tag  [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [QCNT_W-1:0] count_reg, count_next;
    logic              ready_reg;
    logic              push, pop;
    logic [CMD_W-1:0]  head_cmd;
    logic [LA_W-1:0]   head_line;
    logic [TAG_W-1:0]  head_tag;
    logic              unused_addr_bits;

    logic [PADDR_W-1:0] base_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   issued_reg, received_reg;
    logic [BEAT_W-1:0]  beat_reg [BEATS];
    logic [BEATS-1:0]   beat_we;
    logic               capture, cap_last, issue_last;

    assign unused_addr_bits = ^i_req_addr[OFF_W-1:0];

    assign push      = i_req_valid && ready_reg;
    assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
    assign head_cmd  = q_cmd[rd_ptr_reg];
    assign head_line = q_line[rd_ptr_reg];
    assign head_tag  = q_tag[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + QCNT_W'(1);
        else if (!push && pop)
            count_next = count_reg - QCNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_cmd[wr_ptr_reg]  <= i_req_cmd;
            q_line[wr_ptr_reg] <= i_req_addr[PADDR_W-1:OFF_W];
            q_tag[wr_ptr_reg]  <= i_req_tag;
        end
    end

    // Ready is registered from the post-update occupancy so it is 0 in reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(REQ_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(REQ_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            ready_reg <= (count_next != QCNT_W'(REQ_DEPTH));
        end
    end

    assign capture    = i_mem_rdata_valid
                        && ((state_reg == ST_ISSUE) || (state_reg == ST_COLLECT))
                        && (received_reg < CNT_W'(BEATS));
    assign cap_last   = capture && (received_reg == CNT_W'(BEATS - 1));
    assign issue_last = (state_reg == ST_ISSUE) && i_mem_rd_ready
                        && (issued_reg == CNT_W'(BEATS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0)
                    state_next = (head_cmd == M_XRD) ? ST_ISSUE : ST_RESP;
            end
            ST_ISSUE: begin
                if (cap_last)
                    state_next = ST_RESP;
                else if (issue_last)
                    state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (cap_last)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                if (i_resp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_we[gi] = capture && (received_reg == CNT_W'(gi));
            assign o_resp_data[gi*BEAT_W +: BEAT_W] = beat_reg[gi];
        end
    endgenerate

    // Beat slots are cleared on every pop, which also gives the zero data of an error response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            base_reg     <= '0;
            tag_reg      <= '0;
            err_reg      <= 1'b0;
            issued_reg   <= '0;
            received_reg <= '0;
            for (int i = 0; i < BEATS; i++)
                beat_reg[i] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        tag_reg      <= head_tag;
                        issued_reg   <= '0;
                        received_reg <= '0;
                        for (int i = 0; i < BEATS; i++)
                            beat_reg[i] <= '0;
                        if (head_cmd == M_XRD) begin
                            base_reg <= {head_line, {OFF_W{1'b0}}};
                            err_reg  <= 1'b0;
                        end else begin
                            err_reg  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (i_mem_rd_ready)
                        issued_reg <= issued_reg + CNT_W'(1);
                end
                ST_RESP: begin
                    if (i_resp_ready)
                        err_reg <= 1'b0;
                end
                default: ;
            endcase
            if (capture)
                received_reg <= received_reg + CNT_W'(1);
            for (int i = 0; i < BEATS; i++)
                if (beat_we[i])
                    beat_reg[i] <= i_mem_rdata;
        end
    end

    assign o_req_ready    = ready_reg;
    assign o_resp_valid   = (state_reg == ST_RESP);
    assign o_resp_tag     = tag_reg;
    assign o_resp_err     = err_reg;
    assign o_mem_rd_valid = (state_reg == ST_ISSUE);
    assign o_mem_rd_addr  = base_reg + PADDR_W'(issued_reg) * PADDR_W'(BEAT_B);

endmodule

// File: tb/tb_msrh_ic_l2_responder.sv
// Randomized bench for msrh_ic_l2_responder: a memory model, a response sink and
// a line-level reference model (expected beat addresses and whole-line responses).
module tb_msrh_ic_l2_responder;

    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [4:0] M_XWR = 5'b00001;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [4:0]   i_req_cmd;
    logic [55:0]  i_req_addr;
    logic [3:0]   i_req_tag;
    logic         o_resp_valid;
    logic         i_resp_ready;
    logic [3:0]   o_resp_tag;
    logic [255:0] o_resp_data;
    logic         o_resp_err;
    logic         o_mem_rd_valid;
    logic         i_mem_rd_ready;
    logic [55:0]  o_mem_rd_addr;
    logic         i_mem_rdata_valid;
    logic [63:0]  i_mem_rdata;

    msrh_ic_l2_responder dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_cmd         (i_req_cmd),
        .i_req_addr        (i_req_addr),
        .i_req_tag         (i_req_tag),
        .o_resp_valid      (o_resp_valid),
        .i_resp_ready      (i_resp_ready),
        .o_resp_tag        (o_resp_tag),
        .o_resp_data       (o_resp_data),
        .o_resp_err        (o_resp_err),
        .o_mem_rd_valid    (o_mem_rd_valid),
        .i_mem_rd_ready    (i_mem_rd_ready),
        .o_mem_rd_addr     (o_mem_rd_addr),
        .i_mem_rdata_valid (i_mem_rdata_valid),
        .i_mem_rdata       (i_mem_rdata)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]   tag;
        logic         err;
        logic [255:0] data;
    } resp_t;

    typedef struct packed {
        logic [55:0] addr;
        logic [31:0] seed;
        int          due;
    } pend_t;

    resp_t       exp_resp[$];
    logic [55:0] exp_addr[$];
    pend_t       pend[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_resp = 0;
    int          n_extra_rd = 0;
    int          n_extra_resp = 0;
    int          beats_driven = 0;
    int          last_beat_cyc = 0;
    int          rd_rise_cyc = 0;
    int          acc_cyc = 0;
    int          rd_mode = 0;    // 0 always ready, 1 toggle, 2 random
    int          resp_mode = 0;  // 0 always ready, 1 stall stall_len cycles, 2 random
    int          stall_len = 5;
    int          mem_lat = 1;    // 0 = random 1..4 per beat
    logic [31:0] seed = 32'h1357_9BDF;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [55:0] a, input logic [31:0] s);
        return {s ^ a[55:24], a[31:0] ^ {s[15:0], s[31:16]}};
    endfunction

    function automatic logic [255:0] line_of(input logic [55:0] addr, input logic [31:0] s);
        logic [255:0] l;
        logic [55:0]  base;
        base = {addr[55:5], 5'b0};
        for (int k = 0; k < 4; k++)
            l[k*64 +: 64] = mem_word(base + 56'(k * 8), s);
        return l;
    endfunction

    // Must be called at a negedge; returns at the negedge after acceptance.
    task automatic send_req(input logic [4:0] cmd, input logic [55:0] addr, input logic [3:0] tag);
        resp_t r;
        int    t;
        i_req_valid = 1'b1;
        i_req_cmd   = cmd;
        i_req_addr  = addr;
        i_req_tag   = tag;
        t = 0;
        while (!o_req_ready && t < 2000) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_req_ready) begin
            chk("req_accept_timeout", o_req_ready, 1);
            i_req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        r.tag = tag;
        r.err = (cmd != M_XRD);
        r.data = (cmd == M_XRD) ? line_of(addr, seed) : '0;
        exp_resp.push_back(r);
        if (cmd == M_XRD)
            for (int k = 0; k < 4; k++)
                exp_addr.push_back({addr[55:5], 5'b0} + 56'(k * 8));
        $display("req tag=%0d cmd=%0d addr=%h accepted at cycle %0d", tag, cmd, addr, cyc);
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int resp_base, input int n_exp);
        int t;
        t = 0;
        while ((exp_resp.size() != 0 || pend.size() != 0 || o_resp_valid || o_mem_rd_valid) && t < 5000) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 5000)
            chk({name, "_drain_timeout"}, exp_resp.size(), 0);
        chk({name, "_resp_count"}, n_resp - resp_base, n_exp);
        chk({name, "_extra_rd"}, n_extra_rd, 0);
        chk({name, "_extra_resp"}, n_extra_resp, 0);
    endtask

    // Memory model: in-order beat returns, latency >= 1.
    initial begin : mem_agent
        pend_t p;
        logic  r;
        logic  tog;
        logic  prev_valid;
        int    lat;
        int    due;
        int    last_due;
        tog = 1'b1;
        prev_valid = 1'b0;
        last_due = 0;
        i_mem_rd_ready = 1'b0;
        i_mem_rdata_valid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                i_mem_rdata_valid = 1'b1;
                i_mem_rdata = mem_word(p.addr, p.seed);
                beats_driven++;
                if (p.addr[4:3] == 2'd3)
                    last_beat_cyc = cyc;
            end else begin
                i_mem_rdata_valid = 1'b0;
                i_mem_rdata = {$urandom, $urandom};
            end
            case (rd_mode)
                1:       r = tog;
                2:       r = ($urandom_range(0, 2) != 0);
                default: r = 1'b1;
            endcase
            tog = ~tog;
            i_mem_rd_ready = r;
            if (o_mem_rd_valid && !prev_valid)
                rd_rise_cyc = cyc;
            prev_valid = o_mem_rd_valid;
            if (o_mem_rd_valid && r) begin
                if (exp_addr.size() == 0)
                    n_extra_rd++;
                else
                    chk("mem_addr", o_mem_rd_addr, exp_addr.pop_front());
                lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
                due = cyc + lat;
                if (due <= last_due)
                    due = last_due + 1;
                last_due = due;
                p.addr = o_mem_rd_addr;
                p.seed = seed;
                p.due  = due;
                pend.push_back(p);
            end
        end
    end

    // Response sink: checks contents, latency and stability under stall.
    initial begin : resp_agent
        resp_t  e;
        logic   r;
        logic   prev_valid;
        logic   prev_hs;
        logic   hs;
        int     stall_cnt;
        logic [3:0]   held_tag;
        logic         held_err;
        logic [255:0] held_data;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        stall_cnt = 0;
        held_tag = '0;
        held_err = 1'b0;
        held_data = '0;
        i_resp_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_resp_valid && !prev_valid) begin
                stall_cnt = 0;
                if (exp_resp.size() != 0 && !exp_resp[0].err)
                    chk("resp_latency", cyc - last_beat_cyc, 1);
            end
            if (o_resp_valid && prev_valid && !prev_hs) begin
                chk("stable_tag", o_resp_tag, held_tag);
                chk("stable_err", o_resp_err, held_err);
                chk("stable_data", o_resp_data, held_data);
            end
            case (resp_mode)
                1:       r = (stall_cnt >= stall_len);
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            if (o_resp_valid && !r)
                stall_cnt++;
            i_resp_ready = r;
            hs = o_resp_valid && r;
            if (hs) begin
                n_resp++;
                if (exp_resp.size() == 0) begin
                    n_extra_resp++;
                end else begin
                    e = exp_resp.pop_front();
                    chk("resp_tag", o_resp_tag, e.tag);
                    chk("resp_err", o_resp_err, e.err);
                    chk("resp_data", o_resp_data, e.data);
                    $display("resp tag=%0d err=%0d data=%h at cycle %0d", o_resp_tag, o_resp_err, o_resp_data, cyc);
                end
            end
            held_tag = o_resp_tag;
            held_err = o_resp_err;
            held_data = o_resp_data;
            prev_valid = o_resp_valid;
            prev_hs = hs;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int b0;
        int t;
        logic [55:0] a;
        i_reset = 1'b1;
        i_req_valid = 1'b0;
        i_req_cmd = '0;
        i_req_addr = '0;
        i_req_tag = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_req_ready", o_req_ready, 0);
        chk("reset_resp_valid", o_resp_valid, 0);
        chk("reset_mem_rd_valid", o_mem_rd_valid, 0);
        chk("reset_resp_tag", o_resp_tag, 0);
        chk("reset_resp_err", o_resp_err, 0);
        chk("reset_resp_data", o_resp_data, 0);
        chk("reset_mem_rd_addr", o_mem_rd_addr, 0);
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        @(negedge i_clk);

        // Single read, latency 1, always ready.
        rd_mode = 0; resp_mode = 0; mem_lat = 1;
        base = n_resp;
        send_req(M_XRD, 56'h0000_0080_0000_14, 4'd3);
        b0 = acc_cyc;
        drain("single", base, 1);
        chk("issue_latency", rd_rise_cyc - b0, 2);

        // Back-pressure on both memory request and response.
        rd_mode = 1; resp_mode = 1; stall_len = 5;
        base = n_resp;
        send_req(M_XRD, 56'h12_3456_789A_BCC0, 4'd9);
        drain("backpressure", base, 1);

        // Queue full while the FSM holds a stalled response.
        rd_mode = 0; resp_mode = 1; stall_len = 15; mem_lat = 1;
        base = n_resp;
        send_req(M_XRD, 56'h00_0000_0000_1000, 4'd10);
        send_req(M_XRD, 56'h00_0000_0000_2020, 4'd1);
        send_req(M_XRD, 56'h00_0000_0000_3040, 4'd2);
        chk("qfull_ready", o_req_ready, 0);
        send_req(M_XRD, 56'h00_0000_0000_4060, 4'd3);
        drain("qfull", base, 4);

        // Non-read command.
        resp_mode = 0;
        base = n_resp;
        send_req(M_XWR, 56'h00_0000_0000_5000, 4'd5);
        drain("nonread", base, 1);

        // Latency 3, beats return during Issue; top-of-space line.
        mem_lat = 3;
        base = n_resp;
        send_req(M_XRD, 56'hFF_FFFF_FFFF_FFF8, 4'd12);
        drain("lat3", base, 1);

        // Reset in Collect after two beats; late beats land in Idle.
        mem_lat = 3;
        base = n_resp;
        b0 = beats_driven;
        send_req(M_XRD, 56'h00_0000_4000_0040, 4'd6);
        t = 0;
        while (beats_driven < b0 + 2 && t < 200) begin
            @(posedge i_clk);
            t++;
        end
        if (t >= 200)
            chk("rst_wait_timeout", beats_driven - b0, 2);
        #2 i_reset = 1'b1;
        #1;
        chk("rst_async_mem_rd_valid", o_mem_rd_valid, 0);
        chk("rst_async_resp_valid", o_resp_valid, 0);
        chk("rst_async_req_ready", o_req_ready, 0);
        exp_addr.delete();
        exp_resp.delete();
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        t = 0;
        while (pend.size() != 0 && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        @(negedge i_clk);
        seed = 32'hC0FF_EE11;
        mem_lat = 1;
        send_req(M_XRD, 56'h00_0000_4000_0040, 4'd7);
        drain("reset_mid", base, 1);

        // Randomized traffic.
        rd_mode = 2; resp_mode = 2; mem_lat = 0;
        base = n_resp;
        for (int i = 0; i < 60; i++) begin
            a = 56'({$urandom, $urandom});
            send_req(($urandom_range(0, 7) == 0) ? M_XWR : M_XRD, a, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
        drain("random", base, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
